multiplexor: RTL and testbench

MULTIPLEXOR -- requirements
Module: multiplexor

---
 rtl/multiplexor_if.sv | 24 ++
 rtl/multiplexor.sv | 48 ++++
 tb/tb_multiplexor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/multiplexor_if.sv
// Bus between a driver and the bit-select multiplexor: data word, select index,
// and the combinational plus registered results.
interface multiplexor_if #(
    parameter int N_INPUTS = 20,
    parameter int ADDR_W   = 5
);
    logic [N_INPUTS-1:0] in;
    logic [ADDR_W-1:0]   addr;
    logic                out;
    logic                addr_err;
    logic                out_q;
    logic                err_q;
    logic                err_seen;

    modport master (
        output in, addr,
        input  out, addr_err, out_q, err_q, err_seen
    );

    modport slave (
        input  in, addr,
        output out, addr_err, out_q, err_q, err_seen
    );
endinterface

// File: rtl/multiplexor.sv
// Selects one bit of a data word by index, flags out-of-range indices, and keeps
// a registered copy of both plus a sticky error flag cleared only by reset.
module multiplexor #(
    parameter int N_INPUTS = 20,
    parameter int ADDR_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    multiplexor_if.slave  bus
);

    logic sel;
    logic err;
    logic out_p1;
    logic err_p1;
    logic seen_p1;

    // Extra headroom bit keeps the range compare correct when N_INPUTS == 2**ADDR_W.
    assign err = ({1'b0, bus.addr} >= (ADDR_W + 1)'(N_INPUTS));

    always_comb begin
        sel = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (bus.addr == ADDR_W'(k)) sel = bus.in[k];
        end
    end

    assign bus.out      = sel;
    assign bus.addr_err = err;

    // Stage p1: registered copies and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1  <= 1'b0;
            err_p1  <= 1'b0;
            seen_p1 <= 1'b0;
        end else begin
            out_p1  <= sel;
            err_p1  <= err;
            if (err) seen_p1 <= 1'b1;
        end
    end

    assign bus.out_q    = out_p1;
    assign bus.err_q    = err_p1;
    assign bus.err_seen = seen_p1;

endmodule

// File: tb/tb_multiplexor.sv
// Bench for multiplexor: vector table, random model comparison, and
// hand-written register/reset sequences.
module tb_multiplexor;
    localparam int N  = 20;
    localparam int AW = 5;

    logic clk;
    logic rst_n;

    multiplexor_if #(.N_INPUTS(N), .ADDR_W(AW)) bus ();

    multiplexor #(.N_INPUTS(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [N-1:0]  din;
        logic [AW-1:0] addr;
        logic          exp_out;
        logic          exp_err;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference: selected bit by shifting the word, zero when the index is past the end.
    function automatic logic ref_out(input logic [N-1:0] d, input int a);
        if (a >= N) return 1'b0;
        return 1'((d >> a) & 1);
    endfunction

    function automatic logic ref_err(input int a);
        return (a >= N);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic drive(input logic [N-1:0] d, input logic [AW-1:0] a);
        bus.in   = d;
        bus.addr = a;
        #1;
    endtask

    logic [N-1:0]  rd;
    logic [AW-1:0] ra;
    logic          m_out, m_err, m_seen;

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        bus.in   = '0;
        bus.addr = '0;
        void'($urandom(32'd20240611));

        // Reset state, with combinational path live during reset
        drive(20'h00004, 5'd2);
        check("reset_out_q", bus.out_q, 1'b0);
        check("reset_err_q", bus.err_q, 1'b0);
        check("reset_err_seen", bus.err_seen, 1'b0);
        check("reset_out_live", bus.out, 1'b1);
        drive(20'h00000, 5'd30);
        check("reset_err_live", bus.addr_err, 1'b1);

        // Vector table: walking one, neighbour index, out-of-range indices
        for (int i = 0; i < N; i++) begin
            tbl.push_back('{din: N'(1) << i, addr: AW'(i), exp_out: 1'b1, exp_err: 1'b0});
            tbl.push_back('{din: N'(1) << i, addr: AW'((i + 1) % N), exp_out: 1'b0, exp_err: 1'b0});
        end
        for (int a = N; a < 32; a++)
            tbl.push_back('{din: 20'hFFFFF, addr: AW'(a), exp_out: 1'b0, exp_err: 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].din, tbl[i].addr);
            check($sformatf("tbl%0d_out a=%0d", i, tbl[i].addr), bus.out, tbl[i].exp_out);
            check($sformatf("tbl%0d_err a=%0d", i, tbl[i].addr), bus.addr_err, tbl[i].exp_err);
        end

        // Random combinational pairs against the model
        for (int i = 0; i < 40; i++) begin
            rd = N'($urandom);
            ra = AW'($urandom_range(31, 0));
            drive(rd, ra);
            check($sformatf("rnd%0d_out a=%0d", i, ra), bus.out, ref_out(rd, int'(ra)));
            check($sformatf("rnd%0d_err a=%0d", i, ra), bus.addr_err, ref_err(int'(ra)));
        end

        // Random clocked run: registered copies and sticky flag
        rst_n  = 1'b1;
        m_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rd = N'($urandom);
            ra = (i < 10) ? AW'($urandom_range(N - 1, 0)) : AW'($urandom_range(31, 0));
            drive(rd, ra);
            m_out  = ref_out(rd, int'(ra));
            m_err  = ref_err(int'(ra));
            m_seen = m_seen | m_err;
            tick();
            check($sformatf("clk%0d_out_q", i), bus.out_q, m_out);
            check($sformatf("clk%0d_err_q", i), bus.err_q, m_err);
            check($sformatf("clk%0d_err_seen", i), bus.err_seen, m_seen);
        end

        // Clean start for the hand-written register sequence
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("pre_seq_err_seen", bus.err_seen, 1'b0);

        drive(20'h00008, 5'd3);
        tick();
        check("regpath_out_q", bus.out_q, 1'b1);
        check("regpath_err_q", bus.err_q, 1'b0);
        check("regpath_seen_clear", bus.err_seen, 1'b0);
        drive(20'h00008, 5'd25);
        tick();
        check("regpath_err_q_set", bus.err_q, 1'b1);
        check("regpath_err_seen_set", bus.err_seen, 1'b1);
        check("regpath_out_q_zero", bus.out_q, 1'b0);

        // Sticky flag holds with in-range addresses
        drive(20'h00001, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sticky%0d_err_seen", i), bus.err_seen, 1'b1);
            check($sformatf("sticky%0d_err_q", i), bus.err_q, 1'b0);
        end
        check("sticky_out_q", bus.out_q, 1'b1);

        // Asynchronous reset pulse with no clock edge
        rst_n = 1'b0;
        #1;
        check("async_out_q", bus.out_q, 1'b0);
        check("async_err_q", bus.err_q, 1'b0);
        check("async_err_seen", bus.err_seen, 1'b0);
        check("async_out_tracks", bus.out, 1'b1);
        drive(20'h00000, 5'd0);
        check("async_out_tracks0", bus.out, 1'b0);
        tick();
        check("held_reset_out_q", bus.out_q, 1'b0);

        // Release and first edge
        rst_n = 1'b1;
        drive(20'h00001, 5'd0);
        check("release_before_edge", bus.out_q, 1'b0);
        tick();
        check("release_out_q", bus.out_q, 1'b1);
        check("release_err_q", bus.err_q, 1'b0);
        check("release_err_seen", bus.err_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
